// File: rtl/core_seq_ctrl_pkg.sv
// Shared definitions for the convolution-tile sequencer: states, instruction bit map,
// idle instruction word and derived phase lengths.
package core_seq_ctrl_pkg;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int K_W     = 3;
    localparam int IN_W    = 6;
    localparam int O_W     = 4;
    localparam int W_BASE  = 1024;
    localparam int RST_CYC = 11;
    localparam int GAP_CYC = 11;

    localparam int LEN_KIJ  = K_W * K_W;
    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_ONIJ = O_W * O_W;

    localparam int ADDR_W = 11;
    localparam int INST_W = 34;
    localparam int IDX_W  = 4;
    localparam int T_W    = 8;

    localparam int ACC_B      = 33;
    localparam int CEN_PMEM_B = 32;
    localparam int WEN_PMEM_B = 31;
    localparam int A_PMEM_LSB = 20;
    localparam int CEN_XMEM_B = 19;
    localparam int WEN_XMEM_B = 18;
    localparam int A_XMEM_LSB = 7;
    localparam int OFIFO_RD_B = 6;
    localparam int IFIFO_WR_B = 5;
    localparam int IFIFO_RD_B = 4;
    localparam int L0_RD_B    = 3;
    localparam int L0_WR_B    = 2;
    localparam int EXEC_B     = 1;
    localparam int LOAD_B     = 0;

    localparam logic [INST_W-1:0] INST_IDLE = (INST_W'(1) << CEN_PMEM_B) | (INST_W'(1) << WEN_PMEM_B)
                                            | (INST_W'(1) << CEN_XMEM_B) | (INST_W'(1) << WEN_XMEM_B);

    // Active cycles per phase; phases followed by an idle cycle end one count later.
    localparam int IFIFO_ACT = 2 * COL + 1;
    localparam int LOAD_LEN  = ROW + COL;
    localparam int L0_ACT    = 2 * LEN_NIJ + 1;
    localparam int EXEC_ACT  = 2 * LEN_NIJ + ROW + COL;
    localparam int OFIFO_ACT = LEN_NIJ;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_W, S_RST, S_IFIFO_WR, S_LOAD, S_GAP, S_L0_WR, S_EXEC,
        S_OFIFO_RD, S_ACC_RST, S_ACC_RD, S_ACC_TAIL, S_ACC_CHK, S_DONE
    } state_t;

    function automatic int last_t(input state_t s);
        case (s)
            S_RST:      return RST_CYC;
            S_IFIFO_WR: return IFIFO_ACT;
            S_LOAD:     return LOAD_LEN - 1;
            S_GAP:      return GAP_CYC - 1;
            S_L0_WR:    return L0_ACT;
            S_EXEC:     return EXEC_ACT;
            S_OFIFO_RD: return OFIFO_ACT;
            S_ACC_RST:  return 1;
            S_ACC_RD:   return LEN_KIJ;
            default:    return 0;
        endcase
    endfunction

endpackage

// File: rtl/core_seq_ctrl_acc_addr_gen.sv
// Accumulation read address addr(o,k) built from running offsets instead of multiplies.
import core_seq_ctrl_pkg::*;

module acc_addr_gen (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step_k,
    input  logic              step_o,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] kx, ky_row, k_base;
    logic [ADDR_W-1:0] ox, oy_row;

    assign addr = k_base + ky_row + kx + oy_row + ox;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx     <= '0;
            ky_row <= '0;
            k_base <= '0;
            ox     <= '0;
            oy_row <= '0;
        end else if (clear) begin
            kx     <= '0;
            ky_row <= '0;
            k_base <= '0;
            ox     <= '0;
            oy_row <= '0;
        end else if (step_o) begin
            kx     <= '0;
            ky_row <= '0;
            k_base <= '0;
            if (ox == ADDR_W'(O_W - 1)) begin
                ox     <= '0;
                oy_row <= oy_row + ADDR_W'(IN_W);
            end else begin
                ox <= ox + 1'b1;
            end
        end else if (step_k) begin
            k_base <= k_base + ADDR_W'(LEN_NIJ);
            if (kx == ADDR_W'(K_W - 1)) begin
                kx     <= '0;
                ky_row <= ky_row + ADDR_W'(IN_W);
            end else begin
                kx <= kx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_seq_ctrl.sv
// Tile sequencer: per-kij weight handshake, core phase sequencing, then per-pixel
// psum accumulation from pmem. All outputs are registered Moore outputs.
import core_seq_ctrl_pkg::*;

module core_seq_ctrl (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              w_valid,
    output logic              w_req,
    output logic [IDX_W-1:0]  kij_idx,
    output logic              xmem_own,
    output logic [INST_W-1:0] inst,
    output logic              core_reset,
    output logic              out_valid,
    output logic [IDX_W-1:0]  onij_idx,
    output logic              busy,
    output logic              done
);

    state_t            state, state_nxt;
    logic [T_W-1:0]    t;
    logic [IDX_W-1:0]  kij, onij;
    logic [ADDR_W-1:0] of_base;
    logic [ADDR_W-1:0] acc_addr;
    logic              phase_end;
    logic              in_acc;

    logic [INST_W-1:0] inst_nxt;
    logic              core_reset_nxt, out_valid_nxt;

    assign phase_end = (t == T_W'(last_t(state)));
    assign in_acc    = (state == S_ACC_RST) || (state == S_ACC_RD)
                    || (state == S_ACC_TAIL) || (state == S_ACC_CHK);

    acc_addr_gen u_addr (
        .clk    (clk),
        .rst_n  (reset_n),
        .clear  (!in_acc),
        .step_k ((state == S_ACC_RD) && (t < T_W'(LEN_KIJ))),
        .step_o (state == S_ACC_CHK),
        .addr   (acc_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        inst_nxt       = INST_IDLE;
        core_reset_nxt = 1'b0;
        out_valid_nxt  = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nxt = S_WAIT_W;
            S_WAIT_W: if (w_valid) state_nxt = S_RST;
            S_RST: begin
                if (t < T_W'(RST_CYC)) core_reset_nxt = 1'b1;
                if (phase_end) state_nxt = S_IFIFO_WR;
            end
            S_IFIFO_WR: begin
                if (t < T_W'(IFIFO_ACT)) begin
                    inst_nxt[IFIFO_WR_B]               = 1'b1;
                    inst_nxt[CEN_XMEM_B]               = 1'b0;
                    inst_nxt[A_XMEM_LSB +: ADDR_W]     = ADDR_W'(W_BASE) + ADDR_W'(t);
                end
                if (phase_end) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                inst_nxt[IFIFO_RD_B] = 1'b1;
                inst_nxt[LOAD_B]     = 1'b1;
                if (phase_end) state_nxt = S_GAP;
            end
            S_GAP: if (phase_end) state_nxt = S_L0_WR;
            S_L0_WR: begin
                if (t < T_W'(L0_ACT)) begin
                    inst_nxt[L0_WR_B]              = 1'b1;
                    inst_nxt[CEN_XMEM_B]           = 1'b0;
                    inst_nxt[A_XMEM_LSB +: ADDR_W] = ADDR_W'(t);
                end
                if (phase_end) state_nxt = S_EXEC;
            end
            S_EXEC: begin
                if (t < T_W'(EXEC_ACT)) begin
                    inst_nxt[L0_RD_B] = 1'b1;
                    inst_nxt[EXEC_B]  = 1'b1;
                end
                if (phase_end) state_nxt = S_OFIFO_RD;
            end
            S_OFIFO_RD: begin
                if (t < T_W'(OFIFO_ACT)) begin
                    inst_nxt[OFIFO_RD_B]           = 1'b1;
                    inst_nxt[CEN_PMEM_B]           = 1'b0;
                    inst_nxt[WEN_PMEM_B]           = 1'b0;
                    inst_nxt[A_PMEM_LSB +: ADDR_W] = of_base + ADDR_W'(t);
                end
                if (phase_end)
                    state_nxt = (kij == IDX_W'(LEN_KIJ - 1)) ? S_ACC_RST : S_WAIT_W;
            end
            S_ACC_RST: begin
                if (t == '0) core_reset_nxt = 1'b1;
                if (phase_end) state_nxt = S_ACC_RD;
            end
            S_ACC_RD: begin
                // acc trails the reads by one cycle, so the extra final cycle only accumulates.
                if (t < T_W'(LEN_KIJ)) begin
                    inst_nxt[CEN_PMEM_B]           = 1'b0;
                    inst_nxt[A_PMEM_LSB +: ADDR_W] = acc_addr;
                end
                if (t != '0) inst_nxt[ACC_B] = 1'b1;
                if (phase_end) state_nxt = S_ACC_TAIL;
            end
            S_ACC_TAIL: state_nxt = S_ACC_CHK;
            S_ACC_CHK: begin
                out_valid_nxt = 1'b1;
                state_nxt     = (onij == IDX_W'(LEN_ONIJ - 1)) ? S_DONE : S_ACC_RST;
            end
            S_DONE:   if (start) state_nxt = S_WAIT_W;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t       <= '0;
            kij     <= '0;
            onij    <= '0;
            of_base <= '0;
        end else begin
            t <= (state_nxt != state) ? '0 : t + 1'b1;
            if (((state == S_IDLE) || (state == S_DONE)) && start) begin
                kij     <= '0;
                of_base <= '0;
            end
            if ((state == S_OFIFO_RD) && phase_end) begin
                if (kij != IDX_W'(LEN_KIJ - 1)) begin
                    kij     <= kij + 1'b1;
                    of_base <= of_base + ADDR_W'(LEN_NIJ);
                end else begin
                    onij <= '0;
                end
            end
            if (state == S_ACC_CHK) onij <= onij + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst       <= INST_IDLE;
            core_reset <= 1'b1;
            w_req      <= 1'b0;
            kij_idx    <= '0;
            xmem_own   <= 1'b0;
            out_valid  <= 1'b0;
            onij_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            inst       <= inst_nxt;
            core_reset <= core_reset_nxt;
            w_req      <= (state == S_WAIT_W);
            kij_idx    <= kij;
            xmem_own   <= (state == S_IDLE) || (state == S_WAIT_W) || (state == S_DONE);
            out_valid  <= out_valid_nxt;
            onij_idx   <= onij;
            busy       <= (state != S_IDLE) && (state != S_DONE);
            done       <= (state == S_DONE);
        end
    end

endmodule
